id_pipe_stage: RTL and testbench

Parametrised, pipelined instruction-decode stage for the RV32I/RV64I core. It integrates the register file, the immediate generator and the main control decode behind a registered ID/EX pipeline boundary. It adds WB-to-ID write-through bypass, load-use hazard detection with stall/bubble insertion, and EX-driven flush. It sits between the IF/ID register (upstream) and the execute stage (downstream).

---
 rtl/id_pipe_stage.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_id_pipe_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage.sv
// Instruction-decode stage: register file, immediate generation and control decode
// behind a registered ID/EX boundary, with WB write-through, load-use stall and EX flush.
module id_pipe_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_stall,
    input  logic            ex_flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic [1:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [1:0]      ex_mtr,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);
    localparam logic       BYP_EN    = (BYPASS != 0);

    function automatic logic idx_in_range(input logic [4:0] idx);
        return ({1'b0, idx} < REG_LIMIT);
    endfunction

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
        return XLEN'($signed(ins[31:20]));
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
        return XLEN'($signed({ins[31:25], ins[11:7]}));
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
        return XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] ins);
        return XLEN'($signed({ins[31:12], 12'h000}));
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] ins);
        return XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    endfunction

    // Full 32-entry array; entries at or above NUM_REGS are never written and stay zero.
    logic [XLEN-1:0] rf_r [32];

    logic [6:0]      op_s;
    logic [4:0]      rs1_idx_s;
    logic [4:0]      rs2_idx_s;
    logic [4:0]      rd_idx_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [1:0]      dec_alu_op_s;
    logic            dec_alu_src_s;
    logic            dec_rw_s;
    logic            dec_mr_s;
    logic            dec_mw_s;
    logic            dec_br_s;
    logic            dec_jp_s;
    logic [1:0]      dec_mtr_s;
    logic            op_bad_s;
    logic            rs1_used_s;
    logic            rs2_used_s;
    logic            reg_bad_s;
    logic            illegal_s;
    logic            load_ctl_s;
    logic            hazard_s;

    assign op_s      = if_instr[6:0];
    assign rs1_idx_s = if_instr[19:15];
    assign rs2_idx_s = if_instr[24:20];
    assign rd_idx_s  = if_instr[11:7];

    // Main control decode and immediate selection by opcode.
    always_comb begin
        dec_imm_s     = {XLEN{1'b0}};
        dec_alu_op_s  = 2'b00;
        dec_alu_src_s = 1'b0;
        dec_rw_s      = 1'b0;
        dec_mr_s      = 1'b0;
        dec_mw_s      = 1'b0;
        dec_br_s      = 1'b0;
        dec_jp_s      = 1'b0;
        dec_mtr_s     = 2'b00;
        op_bad_s      = 1'b0;
        rs1_used_s    = 1'b0;
        rs2_used_s    = 1'b0;
        case (op_s)
            OP_R: begin
                dec_rw_s     = 1'b1;
                dec_alu_op_s = 2'b10;
                rs1_used_s   = 1'b1;
                rs2_used_s   = 1'b1;
            end
            OP_IALU: begin
                dec_rw_s      = 1'b1;
                dec_alu_op_s  = 2'b10;
                dec_alu_src_s = 1'b1;
                rs1_used_s    = 1'b1;
                dec_imm_s     = imm_i(if_instr);
            end
            OP_LOAD: begin
                dec_rw_s      = 1'b1;
                dec_mr_s      = 1'b1;
                dec_alu_src_s = 1'b1;
                dec_mtr_s     = 2'b01;
                rs1_used_s    = 1'b1;
                dec_imm_s     = imm_i(if_instr);
            end
            OP_STORE: begin
                dec_mw_s      = 1'b1;
                dec_alu_src_s = 1'b1;
                rs1_used_s    = 1'b1;
                rs2_used_s    = 1'b1;
                dec_imm_s     = imm_s(if_instr);
            end
            OP_BRANCH: begin
                dec_br_s     = 1'b1;
                dec_alu_op_s = 2'b01;
                rs1_used_s   = 1'b1;
                rs2_used_s   = 1'b1;
                dec_imm_s    = imm_b(if_instr);
            end
            OP_JAL: begin
                dec_jp_s  = 1'b1;
                dec_rw_s  = 1'b1;
                dec_mtr_s = 2'b10;
                dec_imm_s = imm_j(if_instr);
            end
            OP_JALR: begin
                dec_jp_s      = 1'b1;
                dec_rw_s      = 1'b1;
                dec_mtr_s     = 2'b10;
                dec_alu_src_s = 1'b1;
                rs1_used_s    = 1'b1;
                dec_imm_s     = imm_i(if_instr);
            end
            OP_LUI: begin
                dec_rw_s      = 1'b1;
                dec_alu_op_s  = 2'b11;
                dec_alu_src_s = 1'b1;
                dec_imm_s     = imm_u(if_instr);
            end
            OP_AUIPC: begin
                dec_rw_s      = 1'b1;
                dec_alu_src_s = 1'b1;
                dec_imm_s     = imm_u(if_instr);
            end
            default: begin
                op_bad_s = 1'b1;
            end
        endcase
    end

    // A used register index beyond the implemented file is illegal and suppresses all side effects.
    always_comb begin
        reg_bad_s = (rs1_used_s && !idx_in_range(rs1_idx_s)) ||
                    (rs2_used_s && !idx_in_range(rs2_idx_s)) ||
                    (dec_rw_s   && !idx_in_range(rd_idx_s));
        illegal_s = op_bad_s || reg_bad_s;
        if (if_valid && !reg_bad_s) begin
            load_ctl_s = 1'b1;
        end else begin
            load_ctl_s = 1'b0;
        end
    end

    // Source operand 1 read with optional WB write-through.
    always_comb begin
        rs1_val_s = {XLEN{1'b0}};
        if ((rs1_idx_s == 5'd0) || !idx_in_range(rs1_idx_s)) begin
            rs1_val_s = {XLEN{1'b0}};
        end else if (BYP_EN && wb_we && (wb_rd == rs1_idx_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = rf_r[rs1_idx_s];
        end
    end

    // Source operand 2 read with optional WB write-through.
    always_comb begin
        rs2_val_s = {XLEN{1'b0}};
        if ((rs2_idx_s == 5'd0) || !idx_in_range(rs2_idx_s)) begin
            rs2_val_s = {XLEN{1'b0}};
        end else if (BYP_EN && wb_we && (wb_rd == rs2_idx_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = rf_r[rs2_idx_s];
        end
    end

    // Load-use detection against the load currently held in ID/EX; a flush overrides the stall.
    always_comb begin
        hazard_s = if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((rs1_used_s && (ex_rd == rs1_idx_s)) ||
                    (rs2_used_s && (ex_rd == rs2_idx_s)));
        if (ex_flush) begin
            id_stall = 1'b0;
        end else begin
            id_stall = hazard_s;
        end
    end

    // Register file write port; independent of stall and flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_we && (wb_rd != 5'd0) && idx_in_range(wb_rd)) begin
            rf_r[wb_rd] <= wb_data;
        end
    end

    // ID/EX boundary: reset, then flush or stall bubble, then normal load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= {XLEN{1'b0}};
            ex_rs1_val   <= {XLEN{1'b0}};
            ex_rs2_val   <= {XLEN{1'b0}};
            ex_imm       <= {XLEN{1'b0}};
            ex_rs1       <= 5'd0;
            ex_rs2       <= 5'd0;
            ex_rd        <= 5'd0;
            ex_funct3    <= 3'd0;
            ex_funct7b5  <= 1'b0;
            ex_alu_op    <= 2'b00;
            ex_alu_src   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_mtr       <= 2'b00;
            ex_illegal   <= 1'b0;
        end else if (ex_flush || id_stall) begin
            // Bubble: data fields keep their previous contents.
            ex_valid     <= 1'b0;
            ex_alu_op    <= 2'b00;
            ex_alu_src   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_mtr       <= 2'b00;
            ex_illegal   <= 1'b0;
        end else begin
            ex_valid     <= if_valid;
            ex_pc        <= if_pc;
            ex_rs1_val   <= rs1_val_s;
            ex_rs2_val   <= rs2_val_s;
            ex_imm       <= dec_imm_s;
            ex_rs1       <= rs1_idx_s;
            ex_rs2       <= rs2_idx_s;
            ex_rd        <= rd_idx_s;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_alu_op    <= load_ctl_s ? dec_alu_op_s : 2'b00;
            ex_alu_src   <= load_ctl_s & dec_alu_src_s;
            ex_reg_write <= load_ctl_s & dec_rw_s;
            ex_mem_read  <= load_ctl_s & dec_mr_s;
            ex_mem_write <= load_ctl_s & dec_mw_s;
            ex_branch    <= load_ctl_s & dec_br_s;
            ex_jump      <= load_ctl_s & dec_jp_s;
            ex_mtr       <= load_ctl_s ? dec_mtr_s : 2'b00;
            ex_illegal   <= if_valid & illegal_s;
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios followed by random
// instruction streams compared against a behavioural decode/pipeline model.
module tb_id_pipe_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, if_valid, ex_flush, wb_we;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;

    logic        id_stall, ex_valid, ex_funct7b5, ex_alu_src, ex_reg_write, ex_mem_read;
    logic        ex_mem_write, ex_branch, ex_jump, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_alu_op, ex_mtr;

    logic        nb_stall, nb_valid, nb_f7, nb_src, nb_rw, nb_mr, nb_mw, nb_br, nb_jp, nb_ill;
    logic [31:0] nb_pc, nb_rs1_val, nb_rs2_val, nb_imm;
    logic [4:0]  nb_rs1, nb_rs2, nb_rd;
    logic [2:0]  nb_f3;
    logic [1:0]  nb_aluop, nb_mtr;

    logic        e_stall, e_valid, e_f7, e_src, e_rw, e_mr, e_mw, e_br, e_jp, e_ill;
    logic [31:0] e_pc, e_rs1_val, e_rs2_val, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_f3;
    logic [1:0]  e_aluop, e_mtr;

    id_pipe_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_stall(id_stall), .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mtr(ex_mtr), .ex_illegal(ex_illegal)
    );

    id_pipe_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_stall(nb_stall), .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(nb_valid), .ex_pc(nb_pc), .ex_rs1_val(nb_rs1_val), .ex_rs2_val(nb_rs2_val),
        .ex_imm(nb_imm), .ex_rs1(nb_rs1), .ex_rs2(nb_rs2), .ex_rd(nb_rd), .ex_funct3(nb_f3),
        .ex_funct7b5(nb_f7), .ex_alu_op(nb_aluop), .ex_alu_src(nb_src),
        .ex_reg_write(nb_rw), .ex_mem_read(nb_mr), .ex_mem_write(nb_mw),
        .ex_branch(nb_br), .ex_jump(nb_jp), .ex_mtr(nb_mtr), .ex_illegal(nb_ill)
    );

    id_pipe_stage #(.XLEN(32), .NUM_REGS(16), .BYPASS(1)) u_rv32e (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_stall(e_stall), .ex_flush(ex_flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(e_valid), .ex_pc(e_pc), .ex_rs1_val(e_rs1_val), .ex_rs2_val(e_rs2_val),
        .ex_imm(e_imm), .ex_rs1(e_rs1), .ex_rs2(e_rs2), .ex_rd(e_rd), .ex_funct3(e_f3),
        .ex_funct7b5(e_f7), .ex_alu_op(e_aluop), .ex_alu_src(e_src),
        .ex_reg_write(e_rw), .ex_mem_read(e_mr), .ex_mem_write(e_mw),
        .ex_branch(e_br), .ex_jump(e_jp), .ex_mtr(e_mtr), .ex_illegal(e_ill)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, v1, v2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [1:0]  aluop;
        logic        src, rw, mr, mw, br, jp;
        logic [1:0]  mtr;
        logic        ill;
    } ex_t;

    ex_t         m_ex;
    logic [31:0] m_regs [32];
    bit          m_stall;
    logic        obs_stall;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    // Architectural decode of one instruction word into the expected ID/EX contents.
    function automatic void m_decode(input logic [31:0] ins, output ex_t d, output bit u1, output bit u2);
        int vi, vs, vb, vj;
        vi = sx(int'(ins[31:20]), 12);
        vs = sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
        vb = sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13);
        vj = sx(int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21);
        d = '0; u1 = 1'b0; u2 = 1'b0;
        d.valid = 1'b1;
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
        d.f3 = ins[14:12]; d.f7 = ins[30];
        case (ins[6:0])
            7'h33: begin d.rw = 1; d.aluop = 2'b10; u1 = 1; u2 = 1; end
            7'h13: begin d.rw = 1; d.aluop = 2'b10; d.src = 1; u1 = 1; d.imm = 32'(vi); end
            7'h03: begin d.rw = 1; d.mr = 1; d.src = 1; d.mtr = 2'b01; u1 = 1; d.imm = 32'(vi); end
            7'h23: begin d.mw = 1; d.src = 1; u1 = 1; u2 = 1; d.imm = 32'(vs); end
            7'h63: begin d.br = 1; d.aluop = 2'b01; u1 = 1; u2 = 1; d.imm = 32'(vb); end
            7'h6f: begin d.jp = 1; d.rw = 1; d.mtr = 2'b10; d.imm = 32'(vj); end
            7'h67: begin d.jp = 1; d.rw = 1; d.mtr = 2'b10; d.src = 1; u1 = 1; d.imm = 32'(vi); end
            7'h37: begin d.rw = 1; d.aluop = 2'b11; d.src = 1; d.imm = 32'(ins[31:12]) << 12; end
            7'h17: begin d.rw = 1; d.src = 1; d.imm = 32'(ins[31:12]) << 12; end
            default: d.ill = 1;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_we && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic ex_t bubble(input ex_t e);
        e.valid = 0; e.aluop = 0; e.src = 0; e.rw = 0; e.mr = 0;
        e.mw = 0; e.br = 0; e.jp = 0; e.mtr = 0; e.ill = 0;
        return e;
    endfunction

    // One clock: check the combinational stall mid-cycle, advance the model, check ID/EX after the edge.
    task automatic cycle();
        ex_t d;
        bit  u1, u2, haz;
        @(negedge clk);
        m_decode(if_instr, d, u1, u2);
        d.pc = if_pc;
        d.v1 = m_read(if_instr[19:15]);
        d.v2 = m_read(if_instr[24:20]);
        haz = if_valid && m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) &&
              ((u1 && m_ex.rd == if_instr[19:15]) || (u2 && m_ex.rd == if_instr[24:20]));
        m_stall = haz && !ex_flush;
        obs_stall = id_stall;
        chk("id_stall", id_stall, m_stall);
        if (!rst_n) begin
            m_ex = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (ex_flush || m_stall) m_ex = bubble(m_ex);
            else if (!if_valid) m_ex = bubble(d);
            else m_ex = d;
            if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
        chk("ctrl", {ex_valid, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_branch, ex_jump, ex_mtr, ex_illegal},
                    {m_ex.valid, m_ex.aluop, m_ex.src, m_ex.rw, m_ex.mr, m_ex.mw,
                     m_ex.br, m_ex.jp, m_ex.mtr, m_ex.ill});
        chk("pc", ex_pc, m_ex.pc);
        chk("rs1_val", ex_rs1_val, m_ex.v1);
        chk("rs2_val", ex_rs2_val, m_ex.v2);
        chk("imm", ex_imm, m_ex.imm);
        chk("fields", {ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5},
                      {m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.f3, m_ex.f7});
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v; if_instr = ins; if_pc = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_we = we; wb_rd = rd; wb_data = data;
    endtask

    localparam logic [31:0] LW_X5     = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] ADD_X5_X2 = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] ADD_X0_X2 = 32'h00200333;  // add x6,x0,x2

    initial begin
        logic [6:0] ops [10];
        logic [31:0] ins;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ex = '0;
        m_stall = 1'b0;
        rst_n = 1'b0; ex_flush = 1'b0;
        set_in(1'b0, 32'h00000013, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;

        cycle();
        chk("reset_valid", ex_valid, 1'b0);
        chk("reset_imm", ex_imm, 32'd0);
        rst_n = 1'b1;

        wb(1'b1, 5'd1, 32'd15); cycle();
        wb(1'b1, 5'd2, 32'd3); cycle();
        wb(1'b1, 5'd7, 32'h11); cycle();
        wb(1'b0, 5'd0, 32'd0);

        set_in(1'b1, 32'hfe209ee3, 32'h100); cycle();
        chk("bne_rs1", ex_rs1_val, 32'd15);
        chk("bne_rs2", ex_rs2_val, 32'd3);
        chk("bne_imm", ex_imm, 32'hFFFFFFFC);
        chk("bne_branch", ex_branch, 1'b1);
        chk("bne_aluop", ex_alu_op, 2'b01);

        set_in(1'b1, 32'h123451B7, 32'h104); cycle();
        chk("lui_imm", ex_imm, 32'h12345000);
        chk("lui_aluop", ex_alu_op, 2'b11);
        set_in(1'b1, 32'h014000EF, 32'h108); cycle();
        chk("jal_imm", ex_imm, 32'h14);
        chk("jal_jump", ex_jump, 1'b1);
        chk("jal_mtr", ex_mtr, 2'b10);

        set_in(1'b1, LW_X5, 32'h10c); cycle();
        set_in(1'b1, ADD_X5_X2, 32'h110); cycle();
        chk("lu_stall", obs_stall, 1'b1);
        chk("lu_bubble", ex_valid, 1'b0);
        cycle();
        chk("lu_stall_once", obs_stall, 1'b0);
        chk("lu_issue", ex_valid, 1'b1);
        chk("lu_issue_rd", ex_rd, 5'd6);
        set_in(1'b1, LW_X5, 32'h114); cycle();
        set_in(1'b1, ADD_X0_X2, 32'h118); cycle();
        chk("nodep_stall", obs_stall, 1'b0);
        chk("nodep_valid", ex_valid, 1'b1);

        wb(1'b1, 5'd7, 32'hA5);
        set_in(1'b1, 32'h00738433, 32'h11c); cycle();
        chk("byp_rs1", ex_rs1_val, 32'hA5);
        chk("byp_rs2", ex_rs2_val, 32'hA5);
        chk("nobyp_rs1", nb_rs1_val, 32'h11);
        chk("nobyp_rs2", nb_rs2_val, 32'h11);
        wb(1'b1, 5'd0, 32'hFF);
        set_in(1'b1, 32'h00000433, 32'h120); cycle();
        chk("x0_same_cycle", ex_rs1_val, 32'd0);
        wb(1'b0, 5'd0, 32'd0); cycle();
        chk("x0_after_rs1", ex_rs1_val, 32'd0);
        chk("x0_after_rs2", ex_rs2_val, 32'd0);

        set_in(1'b1, LW_X5, 32'h124); cycle();
        set_in(1'b1, ADD_X5_X2, 32'h128); ex_flush = 1'b1; cycle();
        chk("flush_stall", obs_stall, 1'b0);
        chk("flush_valid", ex_valid, 1'b0);
        ex_flush = 1'b0;

        set_in(1'b1, 32'h0000007F, 32'h12c); cycle();
        chk("ill_flag", ex_illegal, 1'b1);
        chk("ill_ctrl", {ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
                         ex_branch, ex_jump, ex_mtr}, 10'd0);
        chk("ill_valid", ex_valid, 1'b1);
        set_in(1'b1, 32'h001088B3, 32'h130); cycle();
        chk("rv32e_ill", e_ill, 1'b1);
        chk("rv32i_legal", ex_illegal, 1'b0);

        set_in(1'b1, LW_X5, 32'h134); cycle();
        set_in(1'b1, ADD_X5_X2, 32'h138); rst_n = 1'b0; cycle();
        chk("rst_mid_stall", obs_stall, 1'b1);
        chk("rst_clear", {ex_valid, ex_pc, ex_imm, ex_mem_read}, 66'd0);
        rst_n = 1'b1; cycle();
        chk("post_rst_stall", obs_stall, 1'b0);
        chk("post_rst_valid", ex_valid, 1'b1);

        for (int n = 0; n < 400; n++) begin
            if (!m_stall) begin
                ins = $urandom;
                ins[6:0] = ($urandom_range(0, 3) == 0) ? 7'h03 : ops[$urandom_range(0, 9)];
                ins[11:7] = 5'($urandom_range(0, 7));
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
                set_in(($urandom_range(0, 7) != 0), ins, if_pc + 32'd4);
            end
            ex_flush = ($urandom_range(0, 9) == 0);
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
